// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
//
// Purpose: carries a DATA_W payload between two pipeline stages. Back-pressure
// (in_ready) is decoded from state flops only, so a downstream stall never
// forms a combinational path back to the upstream stage.
//
// Optional feature macro: PIPE_STALL_CNT_EN (adds the stall_cnt port and counter).
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   flush      in   1       synchronous squash of all buffered entries
//   in_valid   in   1       upstream offers in_data
//   in_ready   out  1       buffer can accept this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a valid entry
//   out_ready  in   1       downstream consumes this cycle
//   out_data   out  DATA_W  head payload, zero when out_valid = 0
//   stall_cnt  out  CNT_W   saturating stall counter (PIPE_STALL_CNT_EN only)

module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_push;
  logic              w_pop;

  // Handshake outputs come straight from the state register.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  // main is cleared whenever the stage empties, so it already reads as NOP.
  assign out_data  = r_main;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Flush wins over any concurrent push; a concurrent pop is still
      // considered taken by the downstream stage.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = in_data;
          end else if (w_push) begin
            // Downstream stalled: park the new word behind the head.
            w_skid_nxt  = in_data;
            w_state_nxt = ST_TWO;
          end else if (w_pop) begin
            w_main_nxt  = '0;
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Cleared by reset only; flush leaves the statistic intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
